led_mem_resp: RTL and testbench
===============================

# led_mem_resp

Synchronous single-port memory responder serving the LED memory controller's `ena`/`wea`/`addra`/`dina`/`douta` port. It holds 16 words of 16 bits and self-initialises them with a known pattern after every reset, so the controller sees deterministic data. Reads have a configurable latency, and a `douta_vld` strobe marks valid read data. It replaces the vendor block RAM in simulation and in FPGA builds that need reset-restorable contents.

## Interface
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 4: address width; depth = 2^ADDR_W.
- `READ_LAT`, default 1: read latency in cycles; legal values 1 or 2.
- `WRITE_MODE`, default 0: same-address write behaviour on `douta`; 0 = read-first, 1 = write-first, 2 = no-change.
- `INIT_BASE`, default 16'h0001: word i is initialised to `INIT_BASE + i`, modulo 2^DATA_W.
- `clka` in 1: single clock; all logic updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: access enable.
- `wea` in 1: write enable; only meaningful when `ena`=1.
- `addra` in ADDR_W: word address.
- `dina` in DATA_W: write data.
- `douta` out DATA_W: read data.
- `douta_vld` out 1: one-cycle strobe; `douta` carries the result of an accepted access.
- `ready` out 1: high once initialisation is complete; accesses are accepted only while high.

## Operation
- The design has two states, INIT and RUN.
- **During `rst`=1:**
  - state = INIT, init pointer = 0.
  - `ready`=0, `douta`=0, `douta_vld`=0.
  - All read pipeline stages are cleared.
  - Memory contents are not modified while reset is held.
- **INIT:**
  - On each rising edge with `rst`=0, write mem[ptr] = `INIT_BASE`+ptr, then ptr = ptr+1.
  - After writing ptr = 2^ADDR_W−1, go to RUN and set `ready`=1.
  - `ena`, `wea`, `addra` and `dina` are ignored in INIT: no write, no read, no `douta_vld`.
- **RUN:**
  - An access is accepted when `ena`=1 at a rising edge.
  - `ena`=1, `wea`=1: mem[`addra`] = `dina`.
  - `ena`=1, `wea`=0: read mem[`addra`].
  - `ena`=0: no access. `douta` holds its last value and `douta_vld`=0 for that slot.
- **`douta` on a write, by `WRITE_MODE`:**
  - 0 (read-first): old contents of mem[`addra`]; `douta_vld` pulses.
  - 1 (write-first): `dina`; `douta_vld` pulses.
  - 2 (no-change): `douta` holds; `douta_vld` stays 0.
- **Address handling:**
  - Addresses decode fully; there are no out-of-range accesses.
  - The init pointer wraps only through the INIT→RUN transition.
- **Reset asserted mid-operation:**
  - Any in-flight read is discarded and does not produce `douta_vld`.
  - The full INIT sequence reruns, and contents return to the initial pattern.

## Timing
- **Initialisation:**
  - `ready` rises on the 16th rising edge after the first edge that samples `rst`=0 (2^ADDR_W edges).
  - The first access can be accepted on the following edge.
- **READ_LAT=1:**
  - Access accepted at edge N.
  - `douta` and `douta_vld` update at edge N.
  - Both are visible during cycle N+1.
- **READ_LAT=2:**
  - Access accepted at edge N; `douta` and `douta_vld` update at edge N+1.
  - The second stage is a plain register: `douta` holds and `douta_vld` drops when the stage carries no valid data.
- **Throughput:** one access per cycle, back-to-back, with no stalls in RUN.
- **Write followed by read of the same address on the next cycle:** the read returns the new data.
- **All outputs are registered;** there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and init:**
  - Pulse `rst` for 3 cycles, keep `ena`=1 with random writes throughout, then release.
  - Required: `ready`=0 for 16 edges, then 1.
  - Read all addresses 0–15 and get 16'h0001–16'h0010; `douta_vld` pulses for each read.
- **Read latency:**
  - With `READ_LAT`=1, then `READ_LAT`=2, read `addra`=4'h7 once.
  - Required: `douta`=16'h0008 and `douta_vld`=1 exactly 1 (resp. 2) edges after acceptance; `douta_vld`=0 otherwise.
- **Write modes:**
  - With mem[3]=16'h0004, write 16'hBEEF to address 3.
  - Required `douta` per mode: 0 → 16'h0004 with `douta_vld`; 1 → 16'hBEEF with `douta_vld`; 2 → unchanged, no `douta_vld`.
  - Next-cycle read of address 3 returns 16'hBEEF in all modes.
- **Back-to-back traffic:**
  - Write 16'hA000+i to addresses i=0–15 on consecutive cycles, then read them on consecutive cycles.
  - Required: 16 consecutive `douta_vld` pulses with matching data in order.
- **Reset mid-operation:**
  - Write 16'h1234 to address 5, issue a read, and assert `rst` on the cycle the read is accepted.
  - Required: no `douta_vld` for that read and `douta`=0.
  - After re-init, address 5 reads 16'h0006.
- **Idle hold:**
  - After a read returning 16'h0002, hold `ena`=0 for 10 cycles.
  - Required: `douta` stays 16'h0002 and `douta_vld` stays 0.

Source files
------------

// File: rtl/led_mem_resp.sv
// Single-port 2^ADDR_W x DATA_W memory responder that reloads INIT_BASE+i after every reset.
// Read latency READ_LAT (1 or 2). No backpressure: one access per cycle once ready is high.
module led_mem_resp #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 4,
   parameter int                READ_LAT   = 1,
   parameter int                WRITE_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_BASE  = 16'h0001
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              ena,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   output logic              douta_vld,
   output logic              ready
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic                ready_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   douta_q;
   logic                douta_vld_q;

   logic                acc_d;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_wa_d;
   logic [DATA_W-1:0]   mem_wd_d;
   logic                rd_vld_d;
   logic [DATA_W-1:0]   rd_dat_d;

   always_comb begin
      acc_d    = (state_q == ST_RUN) && ena;
      mem_we_d = 1'b0;
      mem_wa_d = addra;
      mem_wd_d = dina;
      if (!rst) begin
         if (state_q == ST_INIT) begin
            mem_we_d = 1'b1;
            mem_wa_d = ptr_q;
            mem_wd_d = INIT_BASE + DATA_W'(ptr_q);
         end else if (acc_d && wea) begin
            mem_we_d = 1'b1;
         end
      end
      // Write result on douta depends on WRITE_MODE; no-change writes produce no strobe.
      rd_vld_d = acc_d && !(wea && (WRITE_MODE == 2));
      rd_dat_d = (acc_d && wea && (WRITE_MODE == 1)) ? dina : mem_q[addra];
   end

   always_ff @(posedge clka) begin
      if (mem_we_d) mem_q[mem_wa_d] <= mem_wd_d;
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == '1) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] s1_dat_q;
         logic              s1_vld_q;
         always_ff @(posedge clka) begin
            if (rst) begin
               s1_dat_q    <= '0;
               s1_vld_q    <= 1'b0;
               douta_q     <= '0;
               douta_vld_q <= 1'b0;
            end else begin
               s1_vld_q    <= rd_vld_d;
               if (rd_vld_d) s1_dat_q <= rd_dat_d;
               douta_vld_q <= s1_vld_q;
               if (s1_vld_q) douta_q <= s1_dat_q;
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clka) begin
            if (rst) begin
               douta_q     <= '0;
               douta_vld_q <= 1'b0;
            end else begin
               douta_vld_q <= rd_vld_d;
               if (rd_vld_d) douta_q <= rd_dat_d;
            end
         end
      end
   endgenerate

   assign douta     = douta_q;
   assign douta_vld = douta_vld_q;
   assign ready     = ready_q;
endmodule

// File: tb/tb_led_mem_resp.sv
// Directed bench: four responders (lat1 modes 0/1/2, lat2 mode 0) driven by one shared stimulus table.
module tb_led_mem_resp;
   logic        clka = 1'b0;
   logic        rst, ena, wea;
   logic [3:0]  addra;
   logic [15:0] dina;
   logic [15:0] dq  [4];
   logic        dv  [4];
   logic        rdy [4];

   int nvec = 0;
   int nmis = 0;

   always #5 clka = ~clka;

   led_mem_resp #(.READ_LAT(1), .WRITE_MODE(0)) u0 (.clka(clka), .rst(rst), .ena(ena), .wea(wea),
      .addra(addra), .dina(dina), .douta(dq[0]), .douta_vld(dv[0]), .ready(rdy[0]));
   led_mem_resp #(.READ_LAT(1), .WRITE_MODE(1)) u1 (.clka(clka), .rst(rst), .ena(ena), .wea(wea),
      .addra(addra), .dina(dina), .douta(dq[1]), .douta_vld(dv[1]), .ready(rdy[1]));
   led_mem_resp #(.READ_LAT(1), .WRITE_MODE(2)) u2 (.clka(clka), .rst(rst), .ena(ena), .wea(wea),
      .addra(addra), .dina(dina), .douta(dq[2]), .douta_vld(dv[2]), .ready(rdy[2]));
   led_mem_resp #(.READ_LAT(2), .WRITE_MODE(0)) u3 (.clka(clka), .rst(rst), .ena(ena), .wea(wea),
      .addra(addra), .dina(dina), .douta(dq[3]), .douta_vld(dv[3]), .ready(rdy[3]));

   typedef struct {
      logic        en;
      logic        we;
      logic [3:0]  a;
      logic [15:0] d;
      logic [15:0] x0, x1, x2;
      logic        v0, v1, v2;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic en, input logic we, input logic [3:0] a, input logic [15:0] d,
                               input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                               input logic v0, input logic v1, input logic v2);
      vec_t v;
      v.en = en; v.we = we; v.a = a; v.d = d;
      v.x0 = x0; v.x1 = x1; v.x2 = x2;
      v.v0 = v0; v.v1 = v1; v.v2 = v2;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic init_wait(input bit rnd);
      for (int k = 1; k <= 16; k++) begin
         if (rnd) begin
            ena = 1'b1; wea = 1'b1;
            addra = 4'($urandom); dina = 16'($urandom);
         end
         step();
         for (int u = 0; u < 4; u++)
            chk($sformatf("init%0d ready u%0d", k, u), {15'd0, rdy[u]}, {15'd0, (k == 16)});
         chk($sformatf("init%0d vld u0", k), {15'd0, dv[0]}, 16'd0);
      end
   endtask

   logic [15:0] px;
   logic        pv;

   initial begin
      for (int i = 0; i < 16; i++) add(1, 0, 4'(i), 0, 16'(i+1), 16'(i+1), 16'(i+1), 1, 1, 1);
      add(1, 0, 4'd1, 0, 16'h0002, 16'h0002, 16'h0002, 1, 1, 1);
      for (int i = 0; i < 10; i++) add(0, 0, 4'd0, 0, 16'h0002, 16'h0002, 16'h0002, 0, 0, 0);
      add(1, 0, 4'd7, 0, 16'h0008, 16'h0008, 16'h0008, 1, 1, 1);
      add(1, 1, 4'd3, 16'hBEEF, 16'h0004, 16'hBEEF, 16'h0008, 1, 1, 0);
      add(1, 0, 4'd3, 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1, 1, 1);
      for (int i = 0; i < 16; i++)
         add(1, 1, 4'(i), 16'hA000 + 16'(i), (i == 3) ? 16'hBEEF : 16'(i+1), 16'hA000 + 16'(i), 16'hBEEF, 1, 1, 0);
      for (int i = 0; i < 16; i++)
         add(1, 0, 4'(i), 0, 16'hA000 + 16'(i), 16'hA000 + 16'(i), 16'hA000 + 16'(i), 1, 1, 1);

      // Reset held for 3 edges with writes hammering the port.
      rst = 1'b1; ena = 1'b1; wea = 1'b1; addra = 4'd0; dina = 16'd0;
      for (int k = 0; k < 3; k++) begin
         addra = 4'($urandom); dina = 16'($urandom);
         step();
      end
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("rst dat u%0d", u), dq[u], 16'd0);
         chk($sformatf("rst vld u%0d", u), {15'd0, dv[u]}, 16'd0);
         chk($sformatf("rst ready u%0d", u), {15'd0, rdy[u]}, 16'd0);
      end
      rst = 1'b0;
      init_wait(1'b1);

      px = 16'd0; pv = 1'b0;
      foreach (tbl[k]) begin
         ena = tbl[k].en; wea = tbl[k].we; addra = tbl[k].a; dina = tbl[k].d;
         step();
         chk($sformatf("v%0d u0 dat", k), dq[0], tbl[k].x0);
         chk($sformatf("v%0d u0 vld", k), {15'd0, dv[0]}, {15'd0, tbl[k].v0});
         chk($sformatf("v%0d u1 dat", k), dq[1], tbl[k].x1);
         chk($sformatf("v%0d u1 vld", k), {15'd0, dv[1]}, {15'd0, tbl[k].v1});
         chk($sformatf("v%0d u2 dat", k), dq[2], tbl[k].x2);
         chk($sformatf("v%0d u2 vld", k), {15'd0, dv[2]}, {15'd0, tbl[k].v2});
         chk($sformatf("v%0d u3 dat", k), dq[3], px);
         chk($sformatf("v%0d u3 vld", k), {15'd0, dv[3]}, {15'd0, pv});
         px = tbl[k].x0; pv = tbl[k].v0;
      end

      // Reset mid-operation: lat2 read in flight, and a read coinciding with reset.
      ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = 16'h1234;
      step();
      wea = 1'b0;
      step();
      chk("mid read u0 dat", dq[0], 16'h1234);
      chk("mid read u0 vld", {15'd0, dv[0]}, 16'd1);
      rst = 1'b1;
      step();
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("mid rst dat u%0d", u), dq[u], 16'd0);
         chk($sformatf("mid rst vld u%0d", u), {15'd0, dv[u]}, 16'd0);
         chk($sformatf("mid rst ready u%0d", u), {15'd0, rdy[u]}, 16'd0);
      end
      step();
      rst = 1'b0; ena = 1'b0;
      init_wait(1'b0);
      ena = 1'b1; wea = 1'b0; addra = 4'd5;
      step();
      chk("reinit u0 dat", dq[0], 16'h0006);
      chk("reinit u0 vld", {15'd0, dv[0]}, 16'd1);
      chk("reinit u3 vld early", {15'd0, dv[3]}, 16'd0);
      ena = 1'b0;
      step();
      chk("reinit u3 dat", dq[3], 16'h0006);
      chk("reinit u3 vld", {15'd0, dv[3]}, 16'd1);
      chk("reinit u0 idle vld", {15'd0, dv[0]}, 16'd0);
      chk("reinit u0 idle dat", dq[0], 16'h0006);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
